// File: rtl/spmv_mem_arb_if.sv
// Bundle of the requester-side and shared-memory-side signals of spmv_mem_arb.
// master = PE clients plus memory controller; slave = the arbiter itself.
interface spmv_mem_arb_if #(
  parameter int N_REQ  = 4,
  parameter int LTAG_W = 7,
  parameter int ADDR_W = 48,
  parameter int D_W    = 64
);
  logic [N_REQ-1:0]        req_ld;
  logic [N_REQ-1:0]        req_st;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*D_W-1:0]    req_d;
  logic [N_REQ*LTAG_W-1:0] req_tag;
  logic [N_REQ-1:0]        req_stall;

  logic                    mem_ld;
  logic                    mem_st;
  logic [ADDR_W-1:0]       mem_addr;
  logic [D_W-1:0]          mem_d;
  logic [LTAG_W+1:0]       mem_tag;
  logic                    mem_stall;

  logic                    rsp_mem_push;
  logic [LTAG_W+1:0]       rsp_mem_tag;
  logic [D_W-1:0]          rsp_mem_q;
  logic [N_REQ-1:0]        rsp_push;
  logic [LTAG_W-1:0]       rsp_tag;
  logic [D_W-1:0]          rsp_q;

  logic                    err;

  modport master (
    output req_ld, req_st, req_addr, req_d, req_tag, mem_stall,
           rsp_mem_push, rsp_mem_tag, rsp_mem_q,
    input  req_stall, mem_ld, mem_st, mem_addr, mem_d, mem_tag,
           rsp_push, rsp_tag, rsp_q, err
  );

  modport slave (
    input  req_ld, req_st, req_addr, req_d, req_tag, mem_stall,
           rsp_mem_push, rsp_mem_tag, rsp_mem_q,
    output req_stall, mem_ld, mem_st, mem_addr, mem_d, mem_tag,
           rsp_push, rsp_tag, rsp_q, err
  );
endinterface

// File: rtl/spmv_mem_arb.sv
// Round-robin arbiter sharing one MC request/response port among up to four PE clients.
// Optional SPMV_MEM_ARB_RSP_REG_EN registers the response path (1-cycle latency).
module spmv_mem_arb #(
  parameter int N_REQ  = 4,
  parameter int LTAG_W = 7,
  parameter int ADDR_W = 48,
  parameter int D_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  spmv_mem_arb_if.slave     bus,
  output logic [1:0]        dbg_ptr_o
);
  // Handshake: request i transfers on a rising edge where (req_ld[i] | req_st[i]) & ~req_stall[i];
  // the requester holds strobe/addr/data/tag until then. Responses carry no backpressure.

  logic [1:0]        ptr_q, ptr_d;
  logic              mem_ld_q, mem_ld_d;
  logic              mem_st_q, mem_st_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [D_W-1:0]    mem_d_q, mem_d_d;
  logic [LTAG_W+1:0] mem_tag_q, mem_tag_d;
  logic              err_q, err_d;

  logic [N_REQ-1:0]  req_vld;
  logic              win_vld;
  logic [1:0]        win_idx;
  logic [N_REQ-1:0]  stall_c;
  logic [1:0]        rsp_id;
  logic [N_REQ-1:0]  rsp_push_c;

  assign req_vld = bus.req_ld | bus.req_st;
  assign rsp_id  = bus.rsp_mem_tag[LTAG_W +: 2];

  // Scan from the highest offset down so the last hit is the first valid at/after ptr.
  always_comb begin : arb
    win_vld = 1'b0;
    win_idx = 2'd0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_vld[(int'(ptr_q) + k) % N_REQ]) begin
        win_vld = 1'b1;
        win_idx = 2'((int'(ptr_q) + k) % N_REQ);
      end
    end
    if (bus.mem_stall) win_vld = 1'b0;
  end

  always_comb begin : stall_gen
    stall_c = '1;
    for (int i = 0; i < N_REQ; i++) begin
      stall_c[i] = bus.mem_stall | ~(win_vld && (int'(win_idx) == i));
    end
  end

  assign bus.req_stall = stall_c;

  always_comb begin : req_path
    ptr_d      = ptr_q;
    mem_ld_d   = 1'b0;
    mem_st_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_d_d    = mem_d_q;
    mem_tag_d  = mem_tag_q;
    err_d      = err_q;
    if (win_vld) begin
      // A simultaneous ld+st is issued as a load and flagged.
      mem_ld_d   = bus.req_ld[win_idx];
      mem_st_d   = bus.req_st[win_idx] & ~bus.req_ld[win_idx];
      mem_addr_d = bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
      mem_d_d    = bus.req_d[int'(win_idx)*D_W +: D_W];
      mem_tag_d  = {win_idx, bus.req_tag[int'(win_idx)*LTAG_W +: LTAG_W]};
      ptr_d      = (int'(win_idx) == N_REQ - 1) ? 2'd0 : win_idx + 2'd1;
      if (bus.req_ld[win_idx] & bus.req_st[win_idx]) err_d = 1'b1;
    end
    if (bus.rsp_mem_push && (int'(rsp_id) >= N_REQ)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= 2'd0;
      mem_ld_q   <= 1'b0;
      mem_st_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_d_q    <= '0;
      mem_tag_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      mem_ld_q   <= mem_ld_d;
      mem_st_q   <= mem_st_d;
      mem_addr_q <= mem_addr_d;
      mem_d_q    <= mem_d_d;
      mem_tag_q  <= mem_tag_d;
      err_q      <= err_d;
    end
  end

  assign bus.mem_ld   = mem_ld_q;
  assign bus.mem_st   = mem_st_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_d    = mem_d_q;
  assign bus.mem_tag  = mem_tag_q;
  assign bus.err      = err_q;
  assign dbg_ptr_o    = ptr_q;

  // Ids at or beyond N_REQ match no k and are silently dropped here.
  always_comb begin : rsp_route
    rsp_push_c = '0;
    for (int k = 0; k < N_REQ; k++) begin
      rsp_push_c[k] = bus.rsp_mem_push & ~rst & (int'(rsp_id) == k);
    end
  end

`ifdef SPMV_MEM_ARB_RSP_REG_EN
  logic [N_REQ-1:0]  rsp_push_q;
  logic [LTAG_W-1:0] rsp_tag_q;
  logic [D_W-1:0]    rsp_q_q;

  always_ff @(posedge clk) begin
    if (rst) rsp_push_q <= '0;
    else     rsp_push_q <= rsp_push_c;
  end

  always_ff @(posedge clk) begin
    rsp_tag_q <= bus.rsp_mem_tag[LTAG_W-1:0];
    rsp_q_q   <= bus.rsp_mem_q;
  end

  assign bus.rsp_push = rsp_push_q;
  assign bus.rsp_tag  = rsp_tag_q;
  assign bus.rsp_q    = rsp_q_q;
`else
  assign bus.rsp_push = rsp_push_c;
  assign bus.rsp_tag  = bus.rsp_mem_tag[LTAG_W-1:0];
  assign bus.rsp_q    = bus.rsp_mem_q;
`endif

endmodule

// File: tb/tb_spmv_mem_arb.sv
// Self-checking bench for spmv_mem_arb: reference round-robin model feeding an expected-beat queue.
module tb_spmv_mem_arb;
  localparam int N  = 4;
  localparam int LW = 7;
  localparam int AW = 48;
  localparam int DW = 64;
  localparam int TW = LW + 2;
  localparam int BW = 2 + AW + DW + TW;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_ptr, dbg_ptr3;
  always #5 clk = ~clk;

  spmv_mem_arb_if #(.N_REQ(N), .LTAG_W(LW), .ADDR_W(AW), .D_W(DW)) bus ();
  spmv_mem_arb_if #(.N_REQ(3), .LTAG_W(LW), .ADDR_W(AW), .D_W(DW)) bus3 ();

  spmv_mem_arb #(.N_REQ(N), .LTAG_W(LW), .ADDR_W(AW), .D_W(DW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_ptr_o(dbg_ptr)
  );
  spmv_mem_arb #(.N_REQ(3), .LTAG_W(LW), .ADDR_W(AW), .D_W(DW)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .dbg_ptr_o(dbg_ptr3)
  );

  // ---------------- scoreboard state ----------------
  int             n_tests = 0;
  int             n_fail  = 0;
  logic [BW-1:0]  exp_q[$];
  int             obs_ids[$];
  int             pend[N];
  int             kind[N];   // 0 load, 1 store, 2 load+store
  logic [AW-1:0]  r_addr[N];
  logic [DW-1:0]  r_d[N];
  logic [LW-1:0]  r_tag[N];
  int             mptr = 0;
  logic           rsp_v = 1'b0;
  logic [TW-1:0]  rsp_t = '0;
  logic [DW-1:0]  rsp_d = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic new_fields(input int i);
    r_addr[i] = AW'({$urandom(), $urandom()});
    r_d[i]    = {$urandom(), $urandom()};
    r_tag[i]  = LW'($urandom_range(0, 127));
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      bus.req_ld[i] = (pend[i] > 0) && (kind[i] != 1);
      bus.req_st[i] = (pend[i] > 0) && (kind[i] != 0);
      bus.req_addr[i*AW +: AW] = r_addr[i];
      bus.req_d[i*DW +: DW]    = r_d[i];
      bus.req_tag[i*LW +: LW]  = r_tag[i];
    end
    bus.rsp_mem_push = rsp_v;
    bus.rsp_mem_tag  = rsp_t;
    bus.rsp_mem_q    = rsp_d;
  endtask

  task automatic check_rsp();
    logic [N-1:0] ep;
    ep = '0;
    if (rsp_v && !rst) ep[rsp_t[LW +: 2]] = 1'b1;
    chk("rsp_push", bus.rsp_push, ep);
    if (ep != '0) begin
      chk("rsp_tag", bus.rsp_tag, rsp_t[LW-1:0]);
      chk("rsp_q", bus.rsp_q, rsp_d);
    end
  endtask

  // One clock: drive at negedge, predict before posedge, compare just after posedge.
  task automatic cycle();
    logic [BW-1:0] e;
    int  w;
    bit  acc;
    drive_inputs();
    #1;
    acc = 1'b0;
    w   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (pend[(mptr + k) % N] > 0) begin
        acc = 1'b1;
        w   = (mptr + k) % N;
      end
    end
    if (bus.mem_stall) acc = 1'b0;
    for (int i = 0; i < N; i++) chk("req_stall", bus.req_stall[i], !(acc && (w == i)));
`ifndef SPMV_MEM_ARB_RSP_REG_EN
    check_rsp();
`endif
    if (rst) begin
      mptr = 0;
    end else if (acc) begin
      exp_q.push_back({kind[w] != 1, kind[w] == 1, r_addr[w], r_d[w], 2'(w), r_tag[w]});
      pend[w]--;
      new_fields(w);
      mptr = (w + 1) % N;
    end
    @(posedge clk);
    #1;
`ifdef SPMV_MEM_ARB_RSP_REG_EN
    check_rsp();
`endif
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("mem_ld", bus.mem_ld, e[BW-1]);
      chk("mem_st", bus.mem_st, e[BW-2]);
      chk("mem_addr", bus.mem_addr, e[TW+DW +: AW]);
      chk("mem_d", bus.mem_d, e[TW +: DW]);
      chk("mem_tag", bus.mem_tag, e[TW-1:0]);
      obs_ids.push_back(int'(bus.mem_tag[LW +: 2]));
    end else begin
      chk("idle_ld", bus.mem_ld, 1'b0);
      chk("idle_st", bus.mem_st, 1'b0);
    end
    @(negedge clk);
  endtask

  task automatic reset_cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 0;
      kind[i] = 0;
      new_fields(i);
    end
    bus.mem_stall     = 1'b0;
    bus3.req_ld       = '0;
    bus3.req_st       = '0;
    bus3.req_addr     = '0;
    bus3.req_d        = '0;
    bus3.req_tag      = '0;
    bus3.mem_stall    = 1'b0;
    bus3.rsp_mem_push = 1'b0;
    bus3.rsp_mem_tag  = '0;
    bus3.rsp_mem_q    = '0;

    // Reset values
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_mem_ld", bus.mem_ld, 1'b0);
    chk("rst_mem_st", bus.mem_st, 1'b0);
    chk("rst_addr", bus.mem_addr, '0);
    chk("rst_tag", bus.mem_tag, '0);
    chk("rst_d", bus.mem_d, '0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_ptr", dbg_ptr, 2'd0);
    chk("rst_err3", bus3.err, 1'b0);
    chk("rst_ptr3", dbg_ptr3, 2'd0);
    cycle();

    // Single load from requester 2
    pend[2] = 1; kind[2] = 0; r_addr[2] = 48'h1000; r_tag[2] = 7'd5;
    cycle();
    chk("r2_mem_ld", bus.mem_ld, 1'b1);
    chk("r2_addr", bus.mem_addr, 48'h1000);
    chk("r2_tag", bus.mem_tag, {2'd2, 7'd5});
    chk("r2_ptr", dbg_ptr, 2'd3);
    cycle();

    // Single store from requester 0
    pend[0] = 1; kind[0] = 1;
    cycle();
    chk("st_mem_st", bus.mem_st, 1'b1);
    cycle();

    // Fairness with all four loading
    reset_cycle();
    obs_ids.delete();
    for (int i = 0; i < N; i++) begin pend[i] = 2; kind[i] = 0; end
    for (int c = 0; c < 8; c++) cycle();
    chk("rr_cnt", obs_ids.size(), 8);
    for (int i = 0; i < 8 && i < obs_ids.size(); i++) chk("rr_id", obs_ids[i], i % 4);
    cycle();

    // mem_stall for cycles 3..5 with requesters 0 and 1
    reset_cycle();
    obs_ids.delete();
    pend[0] = 100; pend[1] = 100; kind[0] = 0; kind[1] = 0;
    for (int c = 0; c < 10; c++) begin
      bus.mem_stall = (c >= 3 && c <= 5);
      cycle();
    end
    bus.mem_stall = 1'b0;
    pend[0] = 0; pend[1] = 0;
    chk("stall_cnt", obs_ids.size(), 7);
    for (int i = 0; i < 7 && i < obs_ids.size(); i++) chk("stall_id", obs_ids[i], i % 2);
    cycle();

    // Response to requester 3 alongside a request acceptance
    rsp_v = 1'b1; rsp_t = {2'd3, 7'h12}; rsp_d = 64'hDEAD;
    pend[0] = 1; kind[0] = 0;
    cycle();
    rsp_v = 1'b0;
    cycle();

    // Invalid ld+st pair from requester 1
    chk("err_pre", bus.err, 1'b0);
    pend[1] = 1; kind[1] = 2;
    cycle();
    chk("pair_ld", bus.mem_ld, 1'b1);
    chk("pair_st", bus.mem_st, 1'b0);
    chk("pair_err", bus.err, 1'b1);
    kind[1] = 0;
    for (int c = 0; c < 3; c++) cycle();
    chk("err_sticky", bus.err, 1'b1);

    // Reset coincident with a grant
    pend[1] = 1;
    cycle();
    pend[2] = 1; kind[2] = 0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    pend[2] = 0;
    chk("rstg_mem_ld", bus.mem_ld, 1'b0);
    chk("rstg_ptr", dbg_ptr, 2'd0);
    chk("rstg_err", bus.err, 1'b0);
    pend[0] = 1; kind[0] = 0; pend[3] = 1; kind[3] = 0;
    cycle();
    chk("rstg_first", bus.mem_tag[LW +: 2], 2'd0);
    cycle();
    chk("rstg_second", bus.mem_tag[LW +: 2], 2'd3);
    cycle();

    // Random traffic with stalls and responses
    for (int c = 0; c < 120; c++) begin
      for (int i = 0; i < N; i++) begin
        if (pend[i] == 0 && $urandom_range(0, 2) == 0) begin
          pend[i] = $urandom_range(1, 3);
          kind[i] = $urandom_range(0, 1);
        end
      end
      bus.mem_stall = ($urandom_range(0, 4) == 0);
      rsp_v = 1'($urandom_range(0, 1));
      rsp_t = TW'($urandom());
      rsp_d = {$urandom(), $urandom()};
      cycle();
    end
    bus.mem_stall = 1'b0;
    rsp_v = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    cycle();
    chk("rand_err", bus.err, 1'b0);
    chk("rand_drain", exp_q.size(), 0);

    // N_REQ=3 instance: id 2 is routed, id 3 is dropped and flagged
    bus3.rsp_mem_push = 1'b1;
    bus3.rsp_mem_tag  = {2'd2, 7'h21};
    bus3.rsp_mem_q    = 64'h1234;
`ifndef SPMV_MEM_ARB_RSP_REG_EN
    #1;
    chk("n3_push2", bus3.rsp_push, 3'b100);
    chk("n3_tag2", bus3.rsp_tag, 7'h21);
`endif
    @(posedge clk);
    #1;
`ifdef SPMV_MEM_ARB_RSP_REG_EN
    chk("n3_push2", bus3.rsp_push, 3'b100);
    chk("n3_tag2", bus3.rsp_tag, 7'h21);
`endif
    chk("n3_err_ok", bus3.err, 1'b0);
    @(negedge clk);
    bus3.rsp_mem_tag = {2'd3, 7'h22};
`ifndef SPMV_MEM_ARB_RSP_REG_EN
    #1;
    chk("n3_push3", bus3.rsp_push, 3'b000);
`endif
    @(posedge clk);
    #1;
`ifdef SPMV_MEM_ARB_RSP_REG_EN
    chk("n3_push3", bus3.rsp_push, 3'b000);
`endif
    chk("n3_err", bus3.err, 1'b1);
    @(negedge clk);
    bus3.rsp_mem_push = 1'b0;
    @(negedge clk);
    chk("n3_err_sticky", bus3.err, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
